// File: rtl/regfile_mp.sv
// Multi-read-port register file with hard-wired zero register and a sequential dump engine; REGFILE_FWD_EN adds write-to-read forwarding.
// Reads and dump outputs are registered (1 cycle); writes land on the clock edge.
// No backpressure: reads, writes and dump_req are accepted every cycle; dump_req is ignored while dump_busy.
module regfile_mp #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 32,
   parameter int NUM_READ = 2,
   parameter int ZERO_REG = 31
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [NUM_READ-1:0]          rd_en,
   input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
   output logic [NUM_READ*DATA_W-1:0]   rd_data,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         dump_req,
   output logic                         dump_busy,
   output logic                         dump_valid,
   output logic [ADDR_W-1:0]            dump_idx,
   output logic [DATA_W-1:0]            dump_data,
   output logic                         dump_done
);

`ifdef REGFILE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [1:0]        state;
   logic [ADDR_W-1:0] dump_nxt;

   // Writable and readable addresses are the same set: in range and not the zero register.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (int'(a) != ZERO_REG) && (int'(a) < DEPTH);
   endfunction

   function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      if (addr_ok(a)) begin
         if (FWD && wr_en && (wr_addr == a))
            v = wr_data;
         else
            v = mem[a];
      end
      return v;
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (wr_en && addr_ok(wr_addr)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else begin
         for (int i = 0; i < NUM_READ; i++) begin
            if (rd_en[i])
               rd_data[i*DATA_W +: DATA_W] <= read_val(rd_addr[i*ADDR_W +: ADDR_W]);
         end
      end
   end

   assign dump_nxt  = dump_idx + 1'b1;
   assign dump_busy = (state != S_IDLE);

   // Dump data is fetched on the edge that presents its index, so a later write to a slot already shown is never re-emitted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         dump_valid <= 1'b0;
         dump_done  <= 1'b0;
         dump_idx   <= '0;
         dump_data  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               dump_done <= 1'b0;
               if (dump_req) begin
                  state      <= S_RUN;
                  dump_valid <= 1'b1;
                  dump_idx   <= '0;
                  dump_data  <= read_val('0);
               end
            end
            S_RUN: begin
               if (dump_idx == LAST_IDX) begin
                  state      <= S_DONE;
                  dump_valid <= 1'b0;
                  dump_done  <= 1'b1;
               end else begin
                  dump_idx  <= dump_nxt;
                  dump_data <= read_val(dump_nxt);
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               dump_done <= 1'b0;
            end
            default: begin
               state      <= S_IDLE;
               dump_valid <= 1'b0;
               dump_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues hand-computed expectations, a negedge monitor pops and compares.
module tb_regfile_mp;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic [1:0]   rd_en = '0;
   logic [9:0]   rd_addr = '0;
   logic [127:0] rd_data;
   logic         wr_en = 1'b0;
   logic [4:0]   wr_addr = '0;
   logic [63:0]  wr_data = '0;
   logic         dump_req = 1'b0;
   logic         dump_busy;
   logic         dump_valid;
   logic [4:0]   dump_idx;
   logic [63:0]  dump_data;
   logic         dump_done;

   regfile_mp #(
      .DATA_W(64), .ADDR_W(5), .DEPTH(32), .NUM_READ(2), .ZERO_REG(31)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
      .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
   );

`ifdef REGFILE_FWD_EN
   localparam logic [63:0] R3_SAME_EDGE = 64'h55;
`else
   localparam logic [63:0] R3_SAME_EDGE = 64'h0;
`endif
   localparam logic [63:0] BEEF = 64'hDEAD_BEEF;

   typedef struct {
      bit          done;
      logic [4:0]  idx;
      logic [63:0] data;
   } dexp_t;

   int checks = 0;
   int errors = 0;

   logic [63:0] rq0[$];
   logic [63:0] rq1[$];
   dexp_t       dq[$];
   logic [1:0]  probe = '0;
   logic [1:0]  pend = '0;
   logic [1:0]  prb = '0;
   bit          exp_cont = 1'b0;
   bit          chk_idle = 1'b0;
   dexp_t       me;
   bit          found;

   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // A read or probe issued before an edge produces a port value to compare at the following negedge.
   always @(posedge clock) begin
      pend <= rd_en;
      prb  <= probe;
   end

   always @(negedge clock) begin
      if (!reset_n) begin
         exp_cont <= 1'b0;
         chk_idle <= 1'b0;
      end else begin
         if (pend[0] || prb[0]) begin
            if (rq0.size() == 0) check("rd0_unexpected", 64'(rq0.size()), 64'd1);
            else check("rd0_data", rd_data[63:0], rq0.pop_front());
         end
         if (pend[1] || prb[1]) begin
            if (rq1.size() == 0) check("rd1_unexpected", 64'(rq1.size()), 64'd1);
            else check("rd1_data", rd_data[127:64], rq1.pop_front());
         end
         if (chk_idle) check("busy_drop", 64'(dump_busy), 64'd0);
         if (dump_valid || dump_done) begin
            if (dq.size() == 0) begin
               check("dump_unexpected", {62'd0, dump_valid, dump_done}, 64'd0);
            end else begin
               me = dq.pop_front();
               check("dump_kind", 64'(dump_done), 64'(me.done));
               check("dump_busy", 64'(dump_busy), 64'd1);
               if (!me.done) begin
                  check("dump_idx", 64'(dump_idx), 64'(me.idx));
                  check("dump_data", dump_data, me.data);
               end else begin
                  check("done_valid_low", 64'(dump_valid), 64'd0);
               end
            end
         end else if (exp_cont) begin
            check("dump_gap", 64'(dump_valid | dump_done), 64'd1);
         end
         exp_cont <= dump_valid;
         chk_idle <= dump_done;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      rd_en = '0;
      wr_en = 1'b0;
      dump_req = 1'b0;
      probe = '0;
   endtask

   task automatic rd2(input logic [4:0] a0, input logic [63:0] e0,
                      input logic [4:0] a1, input logic [63:0] e1);
      rd_en = 2'b11;
      rd_addr = {a1, a0};
      rq0.push_back(e0);
      rq1.push_back(e1);
   endtask

   task automatic wr(input logic [4:0] a, input logic [63:0] d);
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
   endtask

   task automatic push_d(input bit dn, input int i, input logic [63:0] d);
      dexp_t e;
      e.done = dn;
      e.idx = 5'(i);
      e.data = d;
      dq.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_rd_data", rd_data[63:0] | rd_data[127:64], 64'd0);
      check("rst_busy", 64'(dump_busy), 64'd0);
      check("rst_valid", 64'(dump_valid), 64'd0);
      check("rst_done", 64'(dump_done), 64'd0);
      check("rst_idx", 64'(dump_idx), 64'd0);
      check("rst_ddata", dump_data, 64'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      for (int a = 0; a < 32; a++) begin
         idle(); rd2(5'(a), 64'd0, 5'(31 - a), 64'd0); step();
      end

      idle(); wr(5'd5, BEEF); step();
      idle(); rd2(5'd5, BEEF, 5'd5, BEEF); wr(5'd31, 64'd7); step();
      idle(); rd2(5'd31, 64'd0, 5'd5, BEEF); step();
      idle(); wr(5'd3, 64'h55); rd2(5'd3, R3_SAME_EDGE, 5'd31, 64'd0); step();
      idle(); wr(5'd31, 64'd9); rd2(5'd3, 64'h55, 5'd31, 64'd0); step();

      // Port 1 loads r5, then its address moves while disabled: value must hold.
      idle(); rd2(5'd5, BEEF, 5'd5, BEEF); step();
      idle(); rd_en = 2'b01; rd_addr = {5'd3, 5'd3}; rq0.push_back(64'h55);
      probe = 2'b10; rq1.push_back(BEEF); step();
      idle(); rd_en = 2'b01; rd_addr = {5'd31, 5'd5}; rq0.push_back(BEEF);
      probe = 2'b10; rq1.push_back(BEEF); step();

      for (int i = 0; i < 32; i++) begin
         idle(); wr(5'(i), 64'(i + 100)); step();
      end

      // r2 is rewritten after its slot (old value dumped), r20 before its slot (new value dumped).
      idle(); dump_req = 1'b1;
      for (int i = 0; i < 32; i++)
         push_d(1'b0, i, (i == 31) ? 64'd0 : (i == 2) ? 64'd102 : (i == 20) ? 64'hBBBB : 64'(i + 100));
      push_d(1'b1, 0, 64'd0);
      step();
      idle(); repeat (5) step();
      wr(5'd2, 64'hAAAA); step();
      idle(); wr(5'd20, 64'hBBBB); step();
      idle(); dump_req = 1'b1; step();
      idle();
      for (int k = 0; k < 80 && dq.size() != 0; k++) step();
      check("dump1_drained", 64'(dq.size()), 64'd0);
      repeat (3) step();

      idle(); dump_req = 1'b1;
      for (int i = 0; i <= 10; i++)
         push_d(1'b0, i, (i == 2) ? 64'hAAAA : 64'(i + 100));
      step();
      idle();
      found = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         if (dump_valid && dump_idx == 5'd10) begin
            found = 1'b1;
            break;
         end
      end
      check("idx10_seen", 64'(found), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid", 64'(dump_valid), 64'd0);
      check("arst_busy", 64'(dump_busy), 64'd0);
      check("arst_done", 64'(dump_done), 64'd0);
      check("arst_idx", 64'(dump_idx), 64'd0);
      check("arst_ddata", dump_data, 64'd0);
      check("arst_rd_data", rd_data[63:0] | rd_data[127:64], 64'd0);
      check("arst_q_left", 64'(dq.size()), 64'd0);
      step();
      step();
      reset_n = 1'b1;
      repeat (5) step();

      for (int a = 0; a < 32; a++) begin
         idle(); rd2(5'(a), 64'd0, 5'(31 - a), 64'd0); step();
      end
      idle(); repeat (3) step();

      check("queues_empty", 64'(rq0.size() + rq1.size() + dq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
